multiplier_iterative: RTL and testbench
=======================================

Name: multiplier_iterative

Overview:
- Sequential, parametrised successor to the single-cycle block-partitioned multiplier: computes the full DATA_W x DATA_W -> 2*DATA_W unsigned product.
- Time-multiplexes LANES BLOCK_W x BLOCK_W block multipliers over ITER cycles, accumulating shifted partial products in a register.
- Sits between operand producers (e.g. Montgomery reduction datapath) and consumers.
- Valid/ready handshakes on both sides.

Parameters:
- DATA_W, 64, operand width in bits; must be a multiple of BLOCK_W.
- BLOCK_W, 16, width of one block multiplier operand.
- LANES, 4, block multipliers instantiated; must divide NB*NB, where NB = DATA_W/BLOCK_W.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- valid_i  in  1  operands valid.
- ready_o  out  1  block can accept operands.
- indata_a_i  in  DATA_W  operand a.
- indata_b_i  in  DATA_W  operand b.
- valid_o  out  1  result valid.
- ready_i  in  1  consumer accepts result.
- outdata_r_o  out  2*DATA_W  product a*b.

Behaviour:
- Derived constants: NB = DATA_W/BLOCK_W, NPP = NB*NB, ITER = NPP/LANES, CNT_W = max(1, clog2(ITER)).
- Reset (asynchronous, active-high, any state): state=IDLE, cnt=0, acc=0, operand regs=0, valid_o=0, ready_o=1, outdata_r_o=0. An in-flight operation is discarded and never produces valid_o.
- FSM states and outputs:
  - IDLE: ready_o=1, valid_o=0.
  - BUSY: ready_o=0, valid_o=0.
  - DONE: valid_o=1, ready_o=0.
- IDLE, valid_i=1: latch a and b, set acc=0 and cnt=0, go to BUSY.
- BUSY, each cycle: lane l (0..LANES-1) handles partial-product index k = cnt*LANES + l.
  - a block = k mod NB; b block = k div NB.
  - acc += sum over lanes of (a_blk*b_blk) << ((k mod NB + k div NB)*BLOCK_W).
  - Adds are 2*DATA_W wide; the final sum never overflows.
- BUSY, cnt = ITER-1: go to DONE; otherwise cnt++.
- Latency: handshake at edge E0; valid_o=1 after edge E_ITER, i.e. ITER cycles. With LANES = NPP, ITER = 1.
- DONE: outdata_r_o = acc, stable while valid_o=1 and ready_i=0.
  - valid_o=1 and ready_i=1: go to IDLE.
- outdata_r_o holds its last value in IDLE and BUSY. Consumers use it only when valid_o=1.
- valid_i in BUSY or DONE is ignored (ready_o=0). The producer holds its operands.
- ready_o and valid_o are registered-state decodes only: no combinational path from ready_i or valid_i.

Optional Feature:
- Macro: MULT_ITER_OVERLAP_EN.
- Defined:
  - In DONE, ready_o = ready_i.
  - If valid_o & ready_i & valid_i, the result retires and the new operands are latched in the same edge: acc=0, cnt=0, go to BUSY.
  - Back-to-back throughput is one product per ITER+1 cycles.
  - ready_o then has a combinational path from ready_i; this is documented for integrators.
- Undefined: behaviour as above; ready_o=0 in DONE, so each op needs an IDLE cycle (throughput ITER+2).

Decomposition:
- Shared package multiplier_pkg holds:
  - defaults DATA_W, BLOCK_W, LANES;
  - derived NB, NPP, ITER;
  - typedef enum logic [1:0] {IDLE, BUSY, DONE} mul_state_e.
- Sub-module: mul_block_unit, a combinational BLOCK_W x BLOCK_W -> 2*BLOCK_W unsigned multiplier, instantiated LANES times.
- Top module holds operand selection, shift/accumulate, FSM and counter.

Test Plan:
- Basic product (defaults, ITER=4): a=3, b=5, ready_i=1 → valid_o exactly 4 cycles after accept, result 15.
- Max operands: a=b=0xFFFF_FFFF_FFFF_FFFF → result 0xFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001; a=0 or b=0 → 0.
- Backpressure: a=0x1_0000_0001, b=0x1_0000, ready_i=0 for 10 cycles → valid_o and result 0x1_0000_0001_0000 held stable; valid_i pulses during hold are ignored; after ready_i=1, IDLE next cycle.
- Reset mid-op: assert rst_i in the 2nd BUSY cycle → all outputs reset immediately; ready_o=1; no valid_o afterwards. A new op a=7, b=9 gives 63.
- Lane sweep: LANES=1 (ITER=16) and LANES=16 (ITER=1) with 1000 random operand pairs each → results match the golden model; latency is 16 and 1 cycles respectively.
- Overlap: with MULT_ITER_OVERLAP_EN, valid_i held with 3 op pairs and ready_i=1 → results back-to-back, valid_o rising every 5 cycles. Without the macro, every 6 cycles.

Source files
------------

// File: rtl/multiplier_pkg.sv
// Shared defaults, derived constants and FSM state type for the iterative multiplier.
package multiplier_pkg;

    localparam int MUL_DATA_W  = 64;
    localparam int MUL_BLOCK_W = 16;
    localparam int MUL_LANES   = 4;

    localparam int MUL_NB   = MUL_DATA_W / MUL_BLOCK_W;
    localparam int MUL_NPP  = MUL_NB * MUL_NB;
    localparam int MUL_ITER = MUL_NPP / MUL_LANES;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mul_state_e;

endpackage

// File: rtl/mul_block_unit.sv
// Combinational BLOCK_W x BLOCK_W -> 2*BLOCK_W unsigned block multiplier.
module mul_block_unit
    import multiplier_pkg::*;
#(
    parameter int BLOCK_W = MUL_BLOCK_W
) (
    input  logic [BLOCK_W-1:0]   a,
    input  logic [BLOCK_W-1:0]   b,
    output logic [2*BLOCK_W-1:0] p
);

    assign p = (2*BLOCK_W)'(a) * (2*BLOCK_W)'(b);

endmodule

// File: rtl/multiplier_iterative.sv
// Iterative DATA_W x DATA_W multiplier: LANES block multipliers reused over ITER cycles.
// Optional macro MULT_ITER_OVERLAP_EN lets a new operand pair be accepted while a result retires.
module multiplier_iterative
    import multiplier_pkg::*;
#(
    parameter int DATA_W  = MUL_DATA_W,
    parameter int BLOCK_W = MUL_BLOCK_W,
    parameter int LANES   = MUL_LANES
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                valid_i,
    output logic                ready_o,
    input  logic [DATA_W-1:0]   indata_a_i,
    input  logic [DATA_W-1:0]   indata_b_i,
    output logic                valid_o,
    input  logic                ready_i,
    output logic [2*DATA_W-1:0] outdata_r_o,
    output mul_state_e          dbg_state
);

    localparam int NB    = DATA_W / BLOCK_W;
    localparam int NPP   = NB * NB;
    localparam int ITER  = NPP / LANES;
    localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
    localparam int PW    = 2 * DATA_W;

    mul_state_e       state, state_d;
    logic [DATA_W-1:0] a_q, b_q;
    logic [PW-1:0]     acc, acc_nxt, res, pp_sum;
    logic [CNT_W-1:0]  cnt;
    logic              accept, last;
    logic [PW-1:0]     lane_pp [LANES];

    // Handshake: a transfer happens on a rising edge where valid and ready are both high.
    // Producer side: valid_i/ready_o; consumer side: valid_o/ready_i.
    assign valid_o = (state == DONE);
`ifdef MULT_ITER_OVERLAP_EN
    // In DONE the slot frees as the result leaves, so ready_o follows ready_i combinationally.
    assign ready_o = (state == IDLE) || ((state == DONE) && ready_i);
`else
    assign ready_o = (state == IDLE);
`endif
    assign accept    = valid_i && ready_o;
    assign last      = (cnt == CNT_W'(ITER - 1));
    assign dbg_state = state;
    assign outdata_r_o = res;

    // Lane l handles partial product k = cnt*LANES + l; a block = k mod NB, b block = k div NB.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [31:0]          k, a_idx, b_idx;
        logic [BLOCK_W-1:0]   blk_a, blk_b;
        logic [2*BLOCK_W-1:0] prod;

        assign k     = 32'(cnt) * 32'(LANES) + 32'(l);
        assign a_idx = k % 32'(NB);
        assign b_idx = k / 32'(NB);
        assign blk_a = BLOCK_W'(a_q >> (a_idx * 32'(BLOCK_W)));
        assign blk_b = BLOCK_W'(b_q >> (b_idx * 32'(BLOCK_W)));

        mul_block_unit #(.BLOCK_W(BLOCK_W)) u_blk (
            .a(blk_a),
            .b(blk_b),
            .p(prod)
        );

        assign lane_pp[l] = PW'(prod) << ((a_idx + b_idx) * 32'(BLOCK_W));
    end

    always_comb begin
        pp_sum = '0;
        for (int l = 0; l < LANES; l++) begin
            pp_sum = pp_sum + lane_pp[l];
        end
    end

    assign acc_nxt = acc + pp_sum;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE: if (valid_i) state_d = BUSY;
            BUSY: if (last) state_d = DONE;
            DONE: if (ready_i) state_d = accept ? BUSY : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The result register is separate from acc so the output holds while the next op accumulates.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            a_q <= '0;
            b_q <= '0;
            acc <= '0;
            cnt <= '0;
            res <= '0;
        end else if (accept) begin
            a_q <= indata_a_i;
            b_q <= indata_b_i;
            acc <= '0;
            cnt <= '0;
        end else if (state == BUSY) begin
            acc <= acc_nxt;
            if (last) begin
                res <= acc_nxt;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_multiplier_iterative.sv
// Directed/table bench for multiplier_iterative, plus LANES=1 and LANES=16 random sweeps.
module tb_multiplier_iterative;
    import multiplier_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_i;

    logic         valid_i, ready_i, ready_o, valid_o;
    logic [63:0]  a_i, b_i;
    logic [127:0] r_o;
    mul_state_e   st;

    logic         s1_valid_i, s1_ready_o, s1_valid_o;
    logic [63:0]  s1_a, s1_b;
    logic [127:0] s1_r;
    mul_state_e   s1_st;

    logic         s16_valid_i, s16_ready_o, s16_valid_o;
    logic [63:0]  s16_a, s16_b;
    logic [127:0] s16_r;
    mul_state_e   s16_st;

    int checks = 0;
    int errors = 0;

    multiplier_iterative dut (
        .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
        .indata_a_i(a_i), .indata_b_i(b_i), .valid_o(valid_o), .ready_i(ready_i),
        .outdata_r_o(r_o), .dbg_state(st)
    );

    multiplier_iterative #(.LANES(1)) dut_l1 (
        .clk_i(clk), .rst_i(rst_i), .valid_i(s1_valid_i), .ready_o(s1_ready_o),
        .indata_a_i(s1_a), .indata_b_i(s1_b), .valid_o(s1_valid_o), .ready_i(1'b1),
        .outdata_r_o(s1_r), .dbg_state(s1_st)
    );

    multiplier_iterative #(.LANES(16)) dut_l16 (
        .clk_i(clk), .rst_i(rst_i), .valid_i(s16_valid_i), .ready_o(s16_ready_o),
        .indata_a_i(s16_a), .indata_b_i(s16_b), .valid_o(s16_valid_o), .ready_i(1'b1),
        .outdata_r_o(s16_r), .dbg_state(s16_st)
    );

    function automatic void check(input string name, input logic [127:0] act,
                                  input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    typedef struct {
        logic [63:0]  a;
        logic [63:0]  b;
        logic [127:0] p;
    } vec_t;

    vec_t vecs[8];

    // Starts at a negedge with the DUT idle; returns at the negedge where valid_o is first seen.
    task automatic run_op(input logic [63:0] a, input logic [63:0] b, input int exp_lat,
                          input logic [127:0] exp_p, input string name);
        int lat;
        check({name, " ready before"}, 128'(ready_o), 128'(1));
        valid_i = 1'b1;
        a_i = a;
        b_i = b;
        @(negedge clk);
        valid_i = 1'b0;
        lat = 0;
        while (!valid_o && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({name, " latency"}, 128'(lat), 128'(exp_lat));
        check({name, " product"}, r_o, exp_p);
    endtask

    logic [127:0] exp_q[$];
    logic [63:0]  ov_a[3], ov_b[3];
    logic         took;
    int           idx, cyc, last_cyc, n_res, period, nval;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b1;
        valid_i = 1'b0; ready_i = 1'b1; a_i = '0; b_i = '0;
        s1_valid_i = 1'b0; s1_a = '0; s1_b = '0;
        s16_valid_i = 1'b0; s16_a = '0; s16_b = '0;

        vecs[0] = '{64'd3, 64'd5, 128'd15};
        vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                    128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001};
        vecs[2] = '{64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 128'd0};
        vecs[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 128'd0};
        vecs[4] = '{64'h8000_0000_0000_0000, 64'd2, 128'h0000_0000_0000_0001_0000_0000_0000_0000};
        vecs[5] = '{64'h1234_5678, 64'h1_0000_0000, 128'h1234_5678_0000_0000};
        vecs[6] = '{64'hFFFF, 64'hFFFF, 128'hFFFE_0001};
        vecs[7] = '{64'h1_0000_0000_0000, 64'h1_0000_0000_0000,
                    128'h0000_0001_0000_0000_0000_0000_0000_0000};

        repeat (2) @(negedge clk);
        check("reset ready_o", 128'(ready_o), 128'(1));
        check("reset valid_o", 128'(valid_o), 128'(0));
        check("reset result", r_o, 128'(0));
        check("reset state", 128'(st), 128'(IDLE));
        rst_i = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].a, vecs[i].b, 4, vecs[i].p, $sformatf("vec%0d", i));
            @(negedge clk);
            check("retire valid_o low", 128'(valid_o), 128'(0));
            check("retire ready_o high", 128'(ready_o), 128'(1));
        end

        // Backpressure: result must hold and valid_i pulses must be ignored.
        ready_i = 1'b0;
        run_op(64'h1_0000_0001, 64'h1_0000, 4, 128'h1_0000_0001_0000, "bp");
        for (int i = 0; i < 10; i++) begin
            valid_i = i[0];
            a_i = {$urandom, $urandom};
            b_i = {$urandom, $urandom};
            @(negedge clk);
            check("bp valid_o held", 128'(valid_o), 128'(1));
            check("bp result held", r_o, 128'h1_0000_0001_0000);
            check("bp ready_o low", 128'(ready_o), 128'(0));
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        @(negedge clk);
        check("bp release valid_o", 128'(valid_o), 128'(0));
        check("bp release ready_o", 128'(ready_o), 128'(1));
        check("bp release state", 128'(st), 128'(IDLE));

        // Reset in the second BUSY cycle discards the operation.
        valid_i = 1'b1; a_i = 64'd3; b_i = 64'd5;
        @(negedge clk);
        valid_i = 1'b0;
        @(negedge clk);
        check("mid state busy", 128'(st), 128'(BUSY));
        rst_i = 1'b1;
        #1;
        check("mid rst ready_o", 128'(ready_o), 128'(1));
        check("mid rst valid_o", 128'(valid_o), 128'(0));
        check("mid rst result", r_o, 128'(0));
        check("mid rst state", 128'(st), 128'(IDLE));
        @(negedge clk);
        rst_i = 1'b0;
        nval = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (valid_o) nval++;
        end
        check("no valid after reset", 128'(nval), 128'(0));
        run_op(64'd7, 64'd9, 4, 128'd63, "post_rst");
        @(negedge clk);

        // Lane sweeps with a golden full-width product.
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    automatic logic [63:0] a = {$urandom, $urandom};
                    automatic logic [63:0] b = {$urandom, $urandom};
                    automatic int lat = 0;
                    s1_valid_i = 1'b1; s1_a = a; s1_b = b;
                    @(negedge clk);
                    s1_valid_i = 1'b0;
                    while (!s1_valid_o && lat < 40) begin
                        @(negedge clk);
                        lat++;
                    end
                    check("l1 latency", 128'(lat), 128'(16));
                    check("l1 product", s1_r, {64'b0, a} * {64'b0, b});
                    @(negedge clk);
                end
            end
            begin
                for (int i = 0; i < 1000; i++) begin
                    automatic logic [63:0] a = {$urandom, $urandom};
                    automatic logic [63:0] b = {$urandom, $urandom};
                    automatic int lat = 0;
                    s16_valid_i = 1'b1; s16_a = a; s16_b = b;
                    @(negedge clk);
                    s16_valid_i = 1'b0;
                    while (!s16_valid_o && lat < 40) begin
                        @(negedge clk);
                        lat++;
                    end
                    check("l16 latency", 128'(lat), 128'(1));
                    check("l16 product", s16_r, {64'b0, a} * {64'b0, b});
                    @(negedge clk);
                end
            end
        join

        // Streaming three ops with valid_i held: results come out at a fixed spacing.
`ifdef MULT_ITER_OVERLAP_EN
        period = 5;
`else
        period = 6;
`endif
        ov_a[0] = 64'd11;                  ov_b[0] = 64'd13;
        ov_a[1] = 64'hDEAD_BEEF;           ov_b[1] = 64'h1_0000;
        ov_a[2] = 64'hFFFF_FFFF_FFFF_FFFF; ov_b[2] = 64'd2;
        for (int i = 0; i < 3; i++) exp_q.push_back({64'b0, ov_a[i]} * {64'b0, ov_b[i]});
        idx = 0; cyc = 0; last_cyc = -1; n_res = 0;
        ready_i = 1'b1;
        valid_i = 1'b1; a_i = ov_a[0]; b_i = ov_b[0];
        while (n_res < 3 && cyc < 100) begin
            took = valid_i && ready_o;
            @(negedge clk);
            cyc++;
            if (took) begin
                idx++;
                if (idx < 3) begin
                    a_i = ov_a[idx];
                    b_i = ov_b[idx];
                end else begin
                    valid_i = 1'b0;
                end
            end
            if (valid_o) begin
                check("stream product", r_o, exp_q.pop_front());
                if (last_cyc >= 0) check("stream period", 128'(cyc - last_cyc), 128'(period));
                last_cyc = cyc;
                n_res++;
            end
        end
        valid_i = 1'b0;
        check("stream result count", 128'(n_res), 128'(3));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
